sprite_layer_renderer: RTL
==========================

Name: sprite_layer_renderer

Overview:
- Parametrised, positioned and animated sprite renderer. Successor to the full-screen stretched single-image sprite blocks.
- Places one W x H sprite at a runtime screen position, with power-of-two integer scaling, optional horizontal flip, a transparent palette index, and multi-frame animation stored as consecutive frames in one external ROM.
- Sits between the VGA controller (DrawX/DrawY/blank) and the colour mapper. Emits a palette index plus a valid flag per pixel, so the colour mapper can layer several instances by priority.

Parameters:
- SPR_W, 68, sprite width in ROM pixels
- SPR_H, 64, sprite height in ROM pixels
- NUM_FRAMES, 4, animation frames stored back to back in ROM, frame f at base f*SPR_W*SPR_H
- SCALE_LOG2, 0, on-screen magnification = 2^SCALE_LOG2 in both axes
- IDX_W, 4, palette index width
- ADDR_W, 15, ROM address width; must hold NUM_FRAMES*SPR_W*SPR_H-1
- ROM_LAT, 1, ROM read latency in vga_clk edges (1 or 2)
- TRANSP_IDX, 0, palette index treated as transparent

Ports:
- vga_clk  in  1  pixel clock, single clock domain
- reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video, 0 = blanking
- frame_tick  in  1  one-cycle pulse once per video frame (start of vertical blank)
- sprite_en  in  1  sprite visible when 1; shadowed
- pos_x  in  10  sprite top-left column; shadowed
- pos_y  in  10  sprite top-left row; shadowed
- flip_h  in  1  mirror horizontally when 1; shadowed
- anim_en  in  1  advance animation when 1
- ticks_per_step  in  8  frame_ticks per animation step; 0 is treated as 1
- rom_address  out  ADDR_W  registered ROM read address
- rom_q  in  IDX_W  ROM data, ROM_LAT edges after rom_address
- pixel_index  out  IDX_W  palette index for the delayed pixel
- pixel_valid  out  1  1 = opaque sprite pixel, compositor uses pixel_index
- frame_idx  out  log2(NUM_FRAMES) (min 1)  current animation frame, for debug/score logic

Behaviour:
- Reset, synchronous on vga_clk:
  - Clears rom_address, pixel_index, pixel_valid, frame_idx, the tick counter, all shadow registers and the hit delay line.
  - Reset mid-line: every output is 0 after the next edge.
  - Normal output resumes LAT = ROM_LAT+1 edges after reset deasserts.
- Shadow registers (en_s, px_s, py_s, flip_s):
  - Load sprite_en, pos_x, pos_y and flip_h only on edges where frame_tick=1.
  - Rendering uses only the shadows, so no tearing within a frame.
- Animation:
  - On frame_tick with anim_en=1: tick_cnt increments.
  - When tick_cnt reaches max(ticks_per_step,1)-1, on that same edge tick_cnt clears to 0 and frame_idx increments, wrapping NUM_FRAMES-1 -> 0.
  - anim_en=0 holds both counters.
  - A new frame_idx and new shadows take effect from the first pixel after the tick, together.
- Hit test, stage 0, combinational on the inputs:
  - dx = DrawX-px_s and dy = DrawY-py_s, computed as 11-bit unsigned.
  - hit = blank & en_s & DrawX>=px_s & DrawY>=py_s & dx < (SPR_W<<SCALE_LOG2) & dy < (SPR_H<<SCALE_LOG2).
  - A sprite partially off the right or bottom edge clips; there is no wrap-around.
- Address:
  - lx = dx>>SCALE_LOG2; if flip_s then lx = SPR_W-1-lx.
  - ly = dy>>SCALE_LOG2.
  - rom_address <= frame_idx*SPR_W*SPR_H + ly*SPR_W + lx, registered at edge k.
  - When hit=0, rom_address holds its previous value (don't-care for the ROM, saves toggling).
- Pipeline:
  - hit is delayed ROM_LAT edges, aligned with rom_q.
  - At edge k+ROM_LAT: pixel_valid <= hit_d & (rom_q != TRANSP_IDX), and pixel_index <= rom_q if hit_d, else 0.
  - Fixed latency LAT = ROM_LAT+1 edges from DrawX/DrawY to outputs.
  - Fully pipelined: one pixel per clock, no stalls.
- Boundary cases:
  - pos_x + scaled width > 639: clip.
  - frame_tick coinciding with an active pixel: that pixel still uses the old shadows.
  - ticks_per_step changed mid-count: the compare uses the new value, and tick_cnt >= limit forces a step plus clear.

Test Plan:
- Reset asserted mid-line with sprite covering the screen -> pixel_valid=0, pixel_index=0, rom_address=0 on the following edge; frame_idx=0.
- pos=(100,50), SCALE_LOG2=0, sprite_en=1, frame_tick, then scan row 50 -> pixel_valid first rises for DrawX=100 exactly 2 edges later (ROM_LAT=1); rom_address=0 at DrawX=100 and 67 at DrawX=167; invalid at DrawX=99 and 168.
- SCALE_LOG2=1, flip_h=1, pos=(0,0) -> DrawX=0,1 both give address 67; DrawX=2 gives 66; DrawY=3 row gives base 1*68.
- ROM word = TRANSP_IDX inside the sprite -> pixel_valid=0 for that pixel only; neighbours valid with correct index.
- anim_en=1, ticks_per_step=3, 12 frame_ticks -> frame_idx sequence 0,0,1,1,1,2,2,2,3,3,3,0 (changes on ticks 3,6,9,12); addresses offset by frame_idx*4352; ticks_per_step=0 steps every tick.
- pos_x changed mid-frame without frame_tick -> rendered position unchanged until the next frame_tick; pos_x=600 clips at column 639 with no wrap to column 0.

Source files
------------

// File: rtl/sprite_layer_renderer.sv
// rtl/sprite_layer_renderer.sv - positioned, scaled, flippable, animated sprite layer emitting palette index + valid
module sprite_layer_renderer #(
    parameter int SPR_W      = 68,
    parameter int SPR_H      = 64,
    parameter int NUM_FRAMES = 4,
    parameter int SCALE_LOG2 = 0,
    parameter int IDX_W      = 4,
    parameter int ADDR_W     = 15,
    parameter int ROM_LAT    = 1,
    parameter int TRANSP_IDX = 0,
    localparam int FI_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_tick,
    input  logic              sprite_en,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              flip_h,
    input  logic              anim_en,
    input  logic [7:0]        ticks_per_step,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pixel_index,
    output logic              pixel_valid,
    output logic [FI_W-1:0]   frame_idx
);

    localparam int FRAME_SZ = SPR_W * SPR_H;

    logic               en_s;
    logic               flip_s;
    logic [9:0]         px_s;
    logic [9:0]         py_s;
    logic [7:0]         tick_cnt;
    logic [7:0]         step_lim;
    logic [ROM_LAT-1:0] hit_d;
    logic               hit;
    logic [10:0]        dx;
    logic [10:0]        dy;
    logic [10:0]        lx_raw;
    logic [10:0]        lx;
    logic [10:0]        ly;
    logic [ADDR_W-1:0]  addr_next;

    // Stage 0: hit test and ROM address from the shadowed placement only
    always_comb begin
        dx     = {1'b0, DrawX} - {1'b0, px_s};
        dy     = {1'b0, DrawY} - {1'b0, py_s};
        hit    = blank & en_s & (DrawX >= px_s) & (DrawY >= py_s)
               & (dx < 11'(SPR_W << SCALE_LOG2)) & (dy < 11'(SPR_H << SCALE_LOG2));
        lx_raw = dx >> SCALE_LOG2;
        lx     = flip_s ? (11'(SPR_W - 1) - lx_raw) : lx_raw;
        ly     = dy >> SCALE_LOG2;
        addr_next = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SZ)
                  + ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(lx);
        // A step period of 0 behaves like 1, so compare against max(tps,1)-1
        step_lim = (ticks_per_step == 8'd0) ? 8'd0 : ticks_per_step - 8'd1;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_address <= '0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            frame_idx   <= '0;
            tick_cnt    <= '0;
            en_s        <= 1'b0;
            flip_s      <= 1'b0;
            px_s        <= '0;
            py_s        <= '0;
            hit_d       <= '0;
        end else begin
            if (hit)
                rom_address <= addr_next;
            hit_d[0] <= hit;
            for (int i = 1; i < ROM_LAT; i++)
                hit_d[i] <= hit_d[i-1];
            pixel_valid <= hit_d[ROM_LAT-1] & (rom_q != IDX_W'(TRANSP_IDX));
            pixel_index <= hit_d[ROM_LAT-1] ? rom_q : '0;
            // Shadows and animation frame change together, so a frame never tears
            if (frame_tick) begin
                en_s   <= sprite_en;
                flip_s <= flip_h;
                px_s   <= pos_x;
                py_s   <= pos_y;
                if (anim_en) begin
                    if (tick_cnt >= step_lim) begin
                        tick_cnt  <= '0;
                        frame_idx <= (frame_idx == FI_W'(NUM_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule
